alu_req_sequencer: RTL and testbench
====================================

// Module: alu_req_sequencer
// PURPOSE
//  Shares one 3-bit ALU datapath between two requesters. Requests carry A/B/SEL. Grant is round-robin.
//  For each granted request the block latches the operands and drives the ALU for one cycle.
//  It captures the ALU result and returns it with a requester ID over a valid/ready response port.
//  Sits between the user-facing input mux and the ALU; the ALU itself stays combinational and external.
// PARAMETERS
//  DATA_W  3  operand width; the result is DATA_W+1 bits.
//  CNT_W   8  width of the completed-operation counter.
// PORTS
//  clk          in   1         single clock; all state updates on rising edge
//  rst          in   1         synchronous reset, active-high
//  req0_valid   in   1         requester 0 has an operation pending
//  req0_a/_b    in   DATA_W    requester 0 operands
//  req0_sel     in   2         op: 0=A-B, 1=A+B, 2=A^B, 3=A&B
//  req0_ready   out  1         requester 0 operation accepted this cycle
//  req1_*       --   --        same set as req0_* for requester 1
//  alu_a/alu_b  out  DATA_W    operands to the ALU
//  alu_sel      out  2         op select to the ALU
//  alu_result   in   DATA_W+1  combinational result from the ALU
//  rsp_valid    out  1         response held valid
//  rsp_data     out  DATA_W+1  captured ALU result
//  rsp_id       out  1         requester that issued the op
//  rsp_ready    in   1         consumer accepts the response
//  busy         out  1         high in EXEC or RESP
//  op_count     out  CNT_W     completed responses; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs are 0, FSM goes to IDLE, last_grant=1 (requester 0 wins first), and any in-flight op is dropped with no response.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any reqN_valid, pick a winner and assert reqN_ready for that one combinationally this cycle.
//     Latch a/b/sel/id, update last_grant, go to EXEC. The loser's ready stays 0.
//   EXEC: alu_a/b/sel are driven from the latches. At the clock edge, capture alu_result into rsp_data, set rsp_valid=1, and go to RESP.
//   RESP: rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1. On handshake: rsp_valid=0, op_count+1, go to IDLE.
//  Arbitration: if only one requester is valid, it wins. If both are valid, the one that is not last_grant wins, so strict alternation under contention.
//  No request is accepted outside IDLE; reqN_ready=0 in EXEC and RESP, even in the rsp_ready cycle.
//  Latency: accept at cycle T gives rsp_valid at T+2. Peak throughput is 1 op per 3 cycles.
//  alu_a/b/sel outputs are registered latches: they hold the last op when idle and read 0 after reset.
//  Arithmetic is the ALU's: zero-extended operands, 4-bit wrap. For subtraction, bit 3 is the borrow sign (2-5 gives 4'b1101).
//   The sequencer does not alter the result.
//  rsp_ready high while rsp_valid=0 has no effect. reqN_valid may drop without a handshake; nothing is latched.
//  op_count wraps from 2^CNT_W-1 to 0 without a flag.
// STRUCTURE
//  Shared package alu_pkg holds the SEL encodings (ALU_SUB=0, ALU_ADD=1, ALU_XOR=2, ALU_AND=3) and the FSM state typedef (IDLE/EXEC/RESP).
//  One sub-module, rr_arb2: a 2-way round-robin arbiter. Inputs: req[1:0], last_grant. Outputs: one-hot gnt, gnt_id.
//   It is purely combinational; last_grant is kept in the parent.
//  The parent holds the FSM, the operand/ID latches, the response register and the counter.
// TESTING
//  Bench connects the 3-bit ALU behind alu_* ports.
//  1. After reset, req0 alone sends A=3,B=5,SEL=0.
//     -> req0_ready at T, rsp_valid at T+2, rsp_data=4'hE, rsp_id=0, op_count=1 after handshake.
//  2. Both valid from reset: req0 sends 7+7, req1 sends 6^3.
//     -> first rsp id0 data 4'hE, second rsp id1 data 4'h5, grants alternate 0,1,0,1 while both stay valid.
//  3. Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_data/rsp_id stable, both req*_ready=0, op_count unchanged, and it advances on the first rsp_ready=1.
//  4. Assert rst in EXEC with req1 valid.
//     -> next cycle all outputs are 0, state IDLE, no response is emitted, and req0 wins the next contention.
//  5. Run 256 ops with CNT_W=8 -> op_count returns to 0. Random A/B/SEL results are checked against the reference model; no lost or duplicated IDs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU request sequencer: the ALU op-select codes and
// the sequencer FSM state type.
package alu_pkg;

  localparam int ALU_DATA_W = 3;
  localparam int ALU_CNT_W  = 8;

  typedef enum logic [1:0] {
    ALU_SUB = 2'd0,
    ALU_ADD = 2'd1,
    ALU_XOR = 2'd2,
    ALU_AND = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The requester that was
// not granted last wins a tie; the last-grant register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // One-hot grant; no request gives no grant.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        if (last_grant) begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end else begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept in IDLE, one EXEC cycle driving the ALU, then a held valid/ready response.
module alu_req_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = ALU_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_sel,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_sel,
  output logic              req1_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W:0]   alu_result,
  output logic              rsp_valid,
  output logic [DATA_W:0]   rsp_data,
  output logic              rsp_id,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  seq_state_e        state;
  seq_state_e        state_next;
  logic              last_grant;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [1:0]        lat_sel;
  logic              lat_id;
  logic [1:0]        arb_gnt;
  logic              arb_id;
  logic              accept;
  logic              capture;
  logic              rsp_fire;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_id     (arb_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readies are gated by rst so a request seen in the reset cycle is never
  // reported as accepted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = arb_gnt[0] & ~rst;
        req1_ready = arb_gnt[1] & ~rst;
        accept     = (req0_valid | req1_valid) & ~rst;
      end
      EXEC: begin
        busy    = 1'b1;
        capture = 1'b1;
      end
      RESP: begin
        busy     = 1'b1;
        rsp_fire = rsp_ready;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_sel    <= 2'b00;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        lat_a      <= arb_id ? req1_a   : req0_a;
        lat_b      <= arb_id ? req1_b   : req0_b;
        lat_sel    <= arb_id ? req1_sel : req0_sel;
        lat_id     <= arb_id;
        last_grant <= arb_id;
      end
      if (capture) begin
        rsp_data  <= alu_result;
        rsp_id    <= lat_id;
        rsp_valid <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

  // The ALU operands are the latches themselves, so they hold the last op while idle.
  assign alu_a   = lat_a;
  assign alu_b   = lat_b;
  assign alu_sel = lat_sel;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer: a behavioural 3-bit ALU sits behind
// the alu_* ports; directed vector table plus reset, backpressure and wrap sequences.
module tb_alu_req_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_sel, req1_sel;
  logic       req0_ready, req1_ready;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready;
  logic       busy;
  logic [7:0] op_count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_count;
  logic       tb_last;

  typedef struct {
    logic       v0;
    logic [2:0] a0;
    logic [2:0] b0;
    logic [1:0] s0;
    logic       v1;
    logic [2:0] a1;
    logic [2:0] b1;
    logic [1:0] s1;
    logic       exp_id;
    logic [3:0] exp_data;
    int         stall;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  alu_req_sequencer #(.DATA_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .op_count   (op_count)
  );

  function automatic logic [3:0] aluRef(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    case (s)
      2'd0:    aluRef = {1'b0, a} - {1'b0, b};
      2'd1:    aluRef = {1'b0, a} + {1'b0, b};
      2'd2:    aluRef = {1'b0, a ^ b};
      default: aluRef = {1'b0, a & b};
    endcase
  endfunction

  always_comb alu_result = aluRef(alu_a, alu_b, alu_sel);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0;
    req0_a     = v.a0;
    req0_b     = v.b0;
    req0_sel   = v.s0;
    req1_valid = v.v1;
    req1_a     = v.a1;
    req1_b     = v.b1;
    req1_sel   = v.s1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    exp_count = 8'd0;
    tb_last   = 1'b1;
  endtask

  task automatic checkResp(input logic id, input logic [3:0] data);
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_data", rsp_data, data);
    checkOutput("rsp_id", rsp_id, id);
    checkOutput("busy_resp", busy, 1);
    checkOutput("ready_resp", {req1_ready, req0_ready}, 0);
    checkOutput("op_count_hold", op_count, exp_count);
  endtask

  // One full transaction from IDLE: accept, EXEC, RESP (with optional stall), handshake.
  task automatic runOp(input vec_t v);
    logic [2:0] ea, eb;
    logic [1:0] es;
    ea = v.exp_id ? v.a1 : v.a0;
    eb = v.exp_id ? v.b1 : v.b0;
    es = v.exp_id ? v.s1 : v.s0;
    @(negedge clk);
    applyStimulus(v);
    rsp_ready = 1'b0;
    #1;
    checkOutput("req0_ready_grant", req0_ready, {31'd0, ~v.exp_id});
    checkOutput("req1_ready_grant", req1_ready, {31'd0, v.exp_id});
    checkOutput("busy_idle", busy, 0);
    @(negedge clk);
    #1;
    checkOutput("busy_exec", busy, 1);
    checkOutput("rsp_valid_exec", rsp_valid, 0);
    checkOutput("ready_exec", {req1_ready, req0_ready}, 0);
    checkOutput("alu_a", alu_a, ea);
    checkOutput("alu_b", alu_b, eb);
    checkOutput("alu_sel", alu_sel, es);
    @(negedge clk);
    #1;
    checkResp(v.exp_id, v.exp_data);
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      #1;
      checkResp(v.exp_id, v.exp_data);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("ready_handshake", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_count  = exp_count + 8'd1;
    #1;
    checkOutput("rsp_valid_after", rsp_valid, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("op_count", op_count, exp_count);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 3'd0; req0_b = 3'd0; req0_sel = 2'd0;
    req1_a = 3'd0; req1_b = 3'd0; req1_sel = 2'd0;
    rsp_ready = 1'b0;
    exp_count = 8'd0;
    tb_last = 1'b1;

    // Hand-computed vectors; ids follow strict alternation from last_grant=1 after reset.
    tbl[0]  = '{1'b1, 3'd7, 3'd7, ALU_ADD, 1'b1, 3'd6, 3'd3, ALU_XOR, 1'b0, 4'hE, 0};
    tbl[1]  = '{1'b1, 3'd7, 3'd7, ALU_ADD, 1'b1, 3'd6, 3'd3, ALU_XOR, 1'b1, 4'h5, 0};
    tbl[2]  = '{1'b1, 3'd7, 3'd7, ALU_ADD, 1'b1, 3'd6, 3'd3, ALU_XOR, 1'b0, 4'hE, 5};
    tbl[3]  = '{1'b1, 3'd7, 3'd7, ALU_ADD, 1'b1, 3'd6, 3'd3, ALU_XOR, 1'b1, 4'h5, 0};
    tbl[4]  = '{1'b0, 3'd0, 3'd0, ALU_ADD, 1'b1, 3'd2, 3'd5, ALU_SUB, 1'b1, 4'hD, 0};
    tbl[5]  = '{1'b1, 3'd5, 3'd6, ALU_AND, 1'b1, 3'd1, 3'd1, ALU_ADD, 1'b0, 4'h4, 0};
    tbl[6]  = '{1'b1, 3'd5, 3'd6, ALU_AND, 1'b1, 3'd7, 3'd1, ALU_SUB, 1'b1, 4'h6, 2};
    tbl[7]  = '{1'b1, 3'd0, 3'd0, ALU_SUB, 1'b0, 3'd0, 3'd0, ALU_ADD, 1'b0, 4'h0, 0};
    tbl[8]  = '{1'b1, 3'd0, 3'd7, ALU_SUB, 1'b0, 3'd0, 3'd0, ALU_ADD, 1'b0, 4'h9, 0};
    tbl[9]  = '{1'b0, 3'd0, 3'd0, ALU_ADD, 1'b1, 3'd7, 3'd7, ALU_ADD, 1'b1, 4'hE, 0};
    tbl[10] = '{1'b1, 3'd4, 3'd3, ALU_XOR, 1'b1, 3'd6, 3'd5, ALU_AND, 1'b0, 4'h7, 0};
    tbl[11] = '{1'b1, 3'd4, 3'd3, ALU_XOR, 1'b1, 3'd3, 3'd3, ALU_XOR, 1'b1, 4'h0, 0};

    doReset();
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_alu_a", alu_a, 0);
    checkOutput("reset_alu_sel", alu_sel, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_op_count", op_count, 0);

    $display("[TB] single requester 3-5");
    runOp('{1'b1, 3'd3, 3'd5, ALU_SUB, 1'b0, 3'd0, 3'd0, ALU_ADD, 1'b0, 4'hE, 0});

    $display("[TB] vector table");
    doReset();
    for (int i = 0; i < 12; i++) runOp(tbl[i]);

    $display("[TB] reset during EXEC");
    @(negedge clk);
    applyStimulus('{1'b0, 3'd0, 3'd0, ALU_ADD, 1'b1, 3'd1, 3'd2, ALU_ADD, 1'b1, 4'h3, 0});
    #1;
    checkOutput("pre_reset_req1_ready", req1_ready, 1);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req1_valid = 1'b0;
    exp_count = 8'd0;
    #1;
    checkOutput("rst_exec_rsp_valid", rsp_valid, 0);
    checkOutput("rst_exec_rsp_data", rsp_data, 0);
    checkOutput("rst_exec_rsp_id", rsp_id, 0);
    checkOutput("rst_exec_alu_a", alu_a, 0);
    checkOutput("rst_exec_alu_b", alu_b, 0);
    checkOutput("rst_exec_alu_sel", alu_sel, 0);
    checkOutput("rst_exec_busy", busy, 0);
    checkOutput("rst_exec_op_count", op_count, 0);
    checkOutput("rst_exec_ready", {req1_ready, req0_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_exec_no_rsp", rsp_valid, 0);
    end
    runOp('{1'b1, 3'd2, 3'd2, ALU_ADD, 1'b1, 3'd1, 3'd1, ALU_ADD, 1'b0, 4'h4, 0});

    $display("[TB] 256 random ops");
    doReset();
    for (int n = 0; n < 256; n++) begin
      v.v0 = 1'($urandom_range(0, 1));
      v.v1 = 1'($urandom_range(0, 1));
      if (!v.v0 && !v.v1) v.v0 = 1'b1;
      v.a0 = 3'($urandom_range(0, 7));
      v.b0 = 3'($urandom_range(0, 7));
      v.s0 = 2'($urandom_range(0, 3));
      v.a1 = 3'($urandom_range(0, 7));
      v.b1 = 3'($urandom_range(0, 7));
      v.s1 = 2'($urandom_range(0, 3));
      if (v.v0 && v.v1) v.exp_id = ~tb_last;
      else              v.exp_id = v.v1;
      tb_last = v.exp_id;
      v.exp_data = v.exp_id ? aluRef(v.a1, v.b1, v.s1) : aluRef(v.a0, v.b0, v.s0);
      v.stall = $urandom_range(0, 2);
      runOp(v);
    end
    checkOutput("op_count_wrap", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
